prm_edge_mask_collector: RTL
============================

// Module: prm_edge_mask_collector
// PURPOSE
//   Downstream stage of the prm_oblgc_chk* edge checker array. After a new obstacle vector
//   is driven into the checkers, waits for the combinational edge_mask outputs to settle,
//   snapshots all NUM_EDGES mask bits, then streams them out as WORD_W-bit words over a
//   valid/ready handshake to the roadmap search engine, counting blocked edges on the way.
// PARAMETERS
//   NUM_EDGES   256  number of edge_mask bits (one per prm_oblgc_chk instance); >= 1
//   WORD_W      32   output word width; NUM_WORDS = ceil(NUM_EDGES/WORD_W)
//   SETTLE_CYC  2    extra cycles to wait for checker logic to settle before capture; >= 0
// PORTS
//   clk           in   1                      single clock, rising edge
//   rst           in   1                      synchronous, active-high reset
//   start         in   1                      pulse: obstacle inputs to checkers just updated
//   edge_mask_in  in   NUM_EDGES              concatenated edge_mask; bit i = edge i blocked
//   busy          out  1                      high from cycle after accepted start to last handshake
//   out_valid     out  1                      out_data/out_idx/out_last valid
//   out_ready     in   1                      consumer accepts word when out_valid & out_ready
//   out_data      out  WORD_W                 mask bits [idx*WORD_W +: WORD_W]; pad bits = 0
//   out_idx       out  clog2(NUM_WORDS)(min 1) index of current word
//   out_last      out  1                      high with final word (idx = NUM_WORDS-1)
//   blocked_cnt   out  clog2(NUM_EDGES+1)     number of 1s among all NUM_EDGES bits
//   done          out  1                      one-cycle pulse after final word accepted
// BEHAVIOUR
//   - Reset: state IDLE; busy, out_valid, out_last, done = 0; out_data, out_idx, blocked_cnt = 0;
//     snapshot register cleared. Reset mid-operation aborts the stream with no done pulse.
//   - FSM IDLE -> SETTLE -> STREAM -> IDLE.
//   - IDLE: start sampled high -> SETTLE, settle counter <= SETTLE_CYC, blocked_cnt <= 0.
//     start is ignored in every state except IDLE (no queuing).
//   - SETTLE: counter decrements each cycle; in the cycle counter == 0, edge_mask_in is
//     registered into the snapshot and the state moves to STREAM, with word index 0.
//     Start sampled at cycle t -> capture at end of cycle t+1+SETTLE_CYC ->
//     out_valid = 1 at cycle t+2+SETTLE_CYC.
//   - STREAM: out_valid = 1 continuously; out_data/out_idx/out_last come from registers and
//     stay stable while out_valid & !out_ready. On handshake: blocked_cnt += popcount(out_data),
//     then the next word is presented in the following cycle (no bubble). Full throughput is
//     one word per cycle.
//   - Handshake on the word with out_last = 1 -> IDLE. In the next cycle: out_valid = 0,
//     busy = 0, done = 1 (one cycle only), and blocked_cnt is final. blocked_cnt holds its
//     value until the next accepted start.
//   - start is accepted in the done cycle (the state is already IDLE).
//   - Pad bits are forced to 0 and are never counted: last word bits >= NUM_EDGES mod WORD_W
//     when NUM_EDGES is not a multiple of WORD_W.
//   - NUM_WORDS = 1: the single word carries out_last = 1.
//   - Changes on edge_mask_in after capture do not affect the stream in progress.
//   - Widths are sized so blocked_cnt never overflows (max value NUM_EDGES).
// TESTING  (NUM_EDGES=40, WORD_W=16, SETTLE_CYC=2 unless noted)
//   1 rst, then start at cycle 0 with mask 40'hFF_0000_0001 and out_ready = 1 ->
//     out_valid first seen at cycle 4; words 16'h0001, 16'h0000, 16'h00FF with idx 0,1,2;
//     out_last only on idx 2; done at cycle 7; blocked_cnt = 9; busy high for cycles 1..6.
//   2 All-ones mask, out_ready toggled 1,0,0,1,... -> out_data and out_idx held during stalls;
//     last word = 16'h00FF (pad bits zero); blocked_cnt = 40; exactly one done pulse.
//   3 start re-pulsed during SETTLE and during STREAM -> ignored; a single sequence of 3 words;
//     start in the done cycle -> a new sequence begins and blocked_cnt is cleared.
//   4 edge_mask_in changed on every cycle after capture -> streamed words equal the value
//     sampled in the capture cycle.
//   5 rst asserted while idx = 1 is stalled -> next cycle out_valid = 0, busy = 0,
//     blocked_cnt = 0, no done pulse; a later start works normally.
//   6 SETTLE_CYC = 0, NUM_EDGES = 16, WORD_W = 16 -> out_valid at t+2, single word with
//     out_last = 1, done at t+3 when out_ready = 1.

Source files
------------

// File: rtl/prm_edge_mask_collector.sv
// Edge-mask collector: waits for checker logic to settle, snapshots the mask,
// then streams it out word by word while counting blocked edges.
module prm_edge_mask_collector #(
  parameter  int NUM_EDGES  = 256,
  parameter  int WORD_W     = 32,
  parameter  int SETTLE_CYC = 2,
  localparam int NUM_WORDS  = (NUM_EDGES + WORD_W - 1) / WORD_W,
  localparam int IDX_W      = (NUM_WORDS > 1) ? $clog2(NUM_WORDS) : 1,
  localparam int CNT_W      = $clog2(NUM_EDGES + 1)
) (
  input  logic                 i_clk,
  input  logic                 i_rst,
  input  logic                 i_start,
  input  logic [NUM_EDGES-1:0] i_edge_mask_in,
  output logic                 o_busy,
  output logic                 o_out_valid,
  input  logic                 i_out_ready,
  output logic [WORD_W-1:0]    o_out_data,
  output logic [IDX_W-1:0]     o_out_idx,
  output logic                 o_out_last,
  output logic [CNT_W-1:0]     o_blocked_cnt,
  output logic                 o_done
);

  localparam int TOT_W = NUM_WORDS * WORD_W;
  localparam int SC_W  = (SETTLE_CYC > 0) ? $clog2(SETTLE_CYC + 1) : 1;

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_WORDS - 1);
  localparam logic [SC_W-1:0]  SC_INIT  = SC_W'(SETTLE_CYC);

  typedef enum logic [1:0] {
    S_IDLE,
    S_SETTLE,
    S_STREAM
  } state_t;

  state_t             r_state;
  logic [SC_W-1:0]    r_cnt;
  logic [TOT_W-1:0]   r_snap;
  logic [IDX_W-1:0]   r_idx;
  logic               r_last;
  logic               r_valid;
  logic               r_busy;
  logic               r_done;
  logic [CNT_W-1:0]   r_blocked;

  logic [TOT_W-1:0]   w_cap;
  logic [CNT_W-1:0]   w_pop;
  logic [IDX_W-1:0]   w_idx_nxt;
  logic               w_hs;

  // Pad bits above NUM_EDGES stay zero so they are never counted.
  always_comb begin
    w_cap                  = '0;
    w_cap[NUM_EDGES-1:0]   = i_edge_mask_in;
  end

  always_comb begin
    w_pop = '0;
    for (int i = 0; i < WORD_W; i++) begin
      w_pop = w_pop + CNT_W'(r_snap[i]);
    end
  end

  assign w_idx_nxt = r_idx + IDX_W'(1);
  assign w_hs      = r_valid & i_out_ready;

  // The snapshot shifts down one word per handshake; the low word is the output.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state   <= S_IDLE;
      r_cnt     <= '0;
      r_snap    <= '0;
      r_idx     <= '0;
      r_last    <= 1'b0;
      r_valid   <= 1'b0;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
      r_blocked <= '0;
    end else begin
      r_done <= 1'b0;
      unique case (r_state)
        S_IDLE: begin
          if (i_start) begin
            r_state   <= S_SETTLE;
            r_cnt     <= SC_INIT;
            r_blocked <= '0;
            r_busy    <= 1'b1;
          end
        end
        S_SETTLE: begin
          if (r_cnt == '0) begin
            r_state <= S_STREAM;
            r_snap  <= w_cap;
            r_idx   <= '0;
            r_last  <= (NUM_WORDS == 1);
            r_valid <= 1'b1;
          end else begin
            r_cnt <= r_cnt - SC_W'(1);
          end
        end
        S_STREAM: begin
          if (w_hs) begin
            r_blocked <= r_blocked + w_pop;
            r_snap    <= r_snap >> WORD_W;
            if (r_last) begin
              r_state <= S_IDLE;
              r_valid <= 1'b0;
              r_busy  <= 1'b0;
              r_last  <= 1'b0;
              r_done  <= 1'b1;
            end else begin
              r_idx  <= w_idx_nxt;
              r_last <= (w_idx_nxt == LAST_IDX);
            end
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign o_busy        = r_busy;
  assign o_out_valid   = r_valid;
  assign o_out_data    = r_snap[WORD_W-1:0];
  assign o_out_idx     = r_idx;
  assign o_out_last    = r_last;
  assign o_blocked_cnt = r_blocked;
  assign o_done        = r_done;

endmodule
